// File: rtl/ovl_win_change_pkg.sv
// Shared types and constants for the window-change checker.
// The OVL_XCHECK_EN macro is consumed by ovl_win_change_checker, not here.
package ovl_win_change_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        WINDOW = 1'b1
    } state_t;

    localparam int FIRE_2STATE = 0;
    localparam int FIRE_XCHECK = 1;
    localparam int FIRE_COVER  = 2;
    localparam int FIRE_WIDTH  = 3;

    localparam int SEV_FATAL   = 0;
    localparam int SEV_ERROR   = 1;
    localparam int SEV_WARNING = 2;
    localparam int SEV_INFO    = 3;

endpackage

// File: rtl/ovl_fire_reporter.sv
// Message and counter side of the checker: prints each violation, counts
// violations and covers, and ends the run when configured as fatal.
module ovl_fire_reporter
    import ovl_win_change_pkg::*;
#(
    parameter int SEVERITY_LEVEL = SEV_ERROR,
    parameter     MSG            = "VIOLATION"
) (
    input logic                  clock,
    input logic                  reset,
    input logic [FIRE_WIDTH-1:0] fire
);

    logic [31:0] violation_count_reg;
    logic [31:0] cover_count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            violation_count_reg <= '0;
            cover_count_reg     <= '0;
        end else begin
            if (fire[FIRE_2STATE]) violation_count_reg <= violation_count_reg + 32'd1;
            if (fire[FIRE_COVER])  cover_count_reg     <= cover_count_reg + 32'd1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset && fire[FIRE_2STATE]) begin
            $display("OVL_WIN_CHANGE %s @%0t (violations so far %0d, covers %0d)",
                     MSG, $time, violation_count_reg, cover_count_reg);
            if (SEVERITY_LEVEL == SEV_FATAL) $finish;
        end
    end
`endif

endmodule

// File: rtl/ovl_win_change_checker.sv
// Window-change checker: test_expr must differ from its window-open value before end_event.
// Optional macro OVL_XCHECK_EN adds X/Z detection on fire[1]; otherwise fire[1] is tied 0.
module ovl_win_change_checker
    import ovl_win_change_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int SEVERITY_LEVEL = SEV_ERROR,
    parameter     MSG            = "VIOLATION"
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start_event,
    input  logic [WIDTH-1:0]      test_expr,
    input  logic                  end_event,
    output logic [FIRE_WIDTH-1:0] fire
);

    state_t                  state_reg,   state_next;
    logic [WIDTH-1:0]        ref_reg,     ref_next;
    logic                    changed_reg, changed_next;
    logic [FIRE_WIDTH-1:0]   fire_reg,    fire_next;

    logic start_ev;
    logic end_ev;
    logic data_ok;
    logic cur_chg;
    logic any_chg;

`ifdef OVL_XCHECK_EN
    logic x_ctl;
    logic x_data;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            ref_reg     <= '0;
            changed_reg <= 1'b0;
            fire_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            ref_reg     <= ref_next;
            changed_reg <= changed_next;
            fire_reg    <= fire_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ref_next     = ref_reg;
        changed_next = changed_reg;
        fire_next    = '0;
        start_ev     = start_event;
        end_ev       = end_event;
        data_ok      = 1'b1;

`ifdef OVL_XCHECK_EN
        // An edge with unknown controls (or unknown data inside a window) is a non-event.
        x_ctl  = $isunknown(start_event) || $isunknown(end_event);
        x_data = (state_reg == WINDOW) && $isunknown(test_expr);
        if (enable) fire_next[FIRE_XCHECK] = x_ctl || x_data;
        if (x_ctl || x_data) begin
            start_ev = 1'b0;
            end_ev   = 1'b0;
            data_ok  = 1'b0;
        end
`endif

        cur_chg = data_ok && (test_expr != ref_reg);
        any_chg = changed_reg || cur_chg;

        if (enable) begin
            case (state_reg)
                IDLE: begin
                    if (start_ev) begin
                        state_next   = WINDOW;
                        ref_next     = test_expr;
                        changed_next = 1'b0;
                    end
                end
                WINDOW: begin
                    if (end_ev) begin
                        fire_next[FIRE_2STATE] = !any_chg;
                        fire_next[FIRE_COVER]  = any_chg;
                        state_next             = IDLE;
                    end else begin
                        changed_next = any_chg;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign fire = fire_reg;

    ovl_fire_reporter #(
        .SEVERITY_LEVEL (SEVERITY_LEVEL),
        .MSG            (MSG)
    ) u_reporter (
        .clock (clock),
        .reset (reset),
        .fire  (fire_reg)
    );

endmodule

// File: tb/tb_ovl_win_change_checker.sv
// Bench for ovl_win_change_checker: directed scenarios plus random traffic vs a window-history model.
module tb_ovl_win_change_checker;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         start_event = 1'b0;
    logic [W-1:0] test_expr = '0;
    logic         end_event = 1'b0;
    logic [2:0]   fire;

    int num_checks = 0;
    int num_errors = 0;

    // Model: a window is its opening value plus every value sampled while open.
    bit           m_open = 1'b0;
    logic [W-1:0] m_ref = '0;
    logic [W-1:0] m_hist[$];
    logic [2:0]   exp_fire = 3'b000;

    ovl_win_change_checker #(
        .WIDTH          (W),
        .SEVERITY_LEVEL (1),
        .MSG            ("VIOLATION")
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .start_event (start_event),
        .test_expr   (test_expr),
        .end_event   (end_event),
        .fire        (fire)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: fire=%b expected %b @%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: fire=%b @%0t", tag, got, $time);
        end
    endtask

    function automatic void model_clear();
        m_open   = 1'b0;
        m_ref    = '0;
        m_hist.delete();
        exp_fire = 3'b000;
    endfunction

    function automatic void model_edge();
        bit diff;
        exp_fire = 3'b000;
        if (!enable) return;
        if (!m_open) begin
            if (start_event) begin
                m_open = 1'b1;
                m_ref  = test_expr;
                m_hist.delete();
            end
        end else begin
            m_hist.push_back(test_expr);
            if (end_event) begin
                diff = 1'b0;
                foreach (m_hist[i]) if (m_hist[i] != m_ref) diff = 1'b1;
                exp_fire = diff ? 3'b100 : 3'b001;
                m_open   = 1'b0;
                m_hist.delete();
            end
        end
    endfunction

    // Called at a negedge: drive, clock once, update model, check at the next negedge.
    task automatic step(input logic s, input logic [W-1:0] d, input logic e,
                        input logic en, input string tag);
        start_event = s;
        test_expr   = d;
        end_event   = e;
        enable      = en;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_eq(tag, fire, exp_fire);
    endtask

    // Asynchronous reset pulse starting between clock edges.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_eq(tag, fire, 3'b000);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        // Reset low for 5 cycles, then high for 5 idle cycles.
        repeat (5) @(negedge clock);
        check_eq("reset_hold", fire, 3'b000);
        reset = 1'b1;
        repeat (5) step(1'b0, '0, 1'b0, 1'b1, "post_reset_idle");

        // 1: unchanged window -> violation
        step(1'b1, 4'd0, 1'b0, 1'b1, "t1_open");
        step(1'b0, 4'd0, 1'b1, 1'b1, "t1_close_violation");
        step(1'b0, 4'd0, 1'b0, 1'b1, "t1_pulse_gone");

        // 2: changed at close -> cover
        step(1'b1, 4'd1, 1'b0, 1'b1, "t2_open");
        step(1'b0, 4'd0, 1'b1, 1'b1, "t2_close_cover");

        // 3: back-to-back windows with start held; close edge never reopens
        step(1'b1, 4'd1, 1'b0, 1'b1, "t3_open_a");
        step(1'b1, 4'd1, 1'b1, 1'b1, "t3_close_a");
        step(1'b1, 4'd1, 1'b0, 1'b1, "t3_open_b");
        step(1'b1, 4'd1, 1'b1, 1'b1, "t3_close_b");
        step(1'b0, 4'd1, 1'b1, 1'b1, "t3_end_in_idle");

        // 4: toggle mid-window, equal at end -> sticky change
        step(1'b1, 4'd0, 1'b0, 1'b1, "t4_open");
        step(1'b0, 4'd1, 1'b0, 1'b1, "t4_toggle_hi");
        step(1'b0, 4'd0, 1'b0, 1'b1, "t4_toggle_lo");
        step(1'b0, 4'd0, 1'b1, 1'b1, "t4_close_sticky");

        // Upper bit only differs: full-width compare
        step(1'b1, 4'b0011, 1'b0, 1'b1, "msb_open");
        step(1'b0, 4'b1011, 1'b1, 1'b1, "msb_close_cover");

        // 5: reset while fire is high and mid-window
        step(1'b1, 4'd5, 1'b0, 1'b1, "t5_open_a");
        step(1'b0, 4'd6, 1'b1, 1'b1, "t5_close_cover");
        async_reset("t5_reset_clears_fire");
        step(1'b1, 4'd5, 1'b0, 1'b1, "t5_open_b");
        async_reset("t5_reset_mid_window");
        step(1'b0, 4'd5, 1'b1, 1'b1, "t5_end_after_reset");

        // 6: enable low freezes the window
        step(1'b1, 4'd3, 1'b0, 1'b1, "t6_open");
        step(1'b0, 4'd3, 1'b1, 1'b0, "t6_end_disabled");
        step(1'b0, 4'd7, 1'b0, 1'b0, "t6_change_disabled");
        step(1'b0, 4'd3, 1'b1, 1'b1, "t6_end_reenabled");

`ifdef OVL_XCHECK_EN
        step(1'b1, 4'd2, 1'b0, 1'b1, "x_open");
        start_event = 1'bx;
        test_expr   = 4'd2;
        end_event   = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_eq("x_start_pulse", fire, 3'b010);
        step(1'b0, 4'd2, 1'b1, 1'b1, "x_window_kept");
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                async_reset("rnd_reset");
            end else begin
                step(($urandom_range(0, 3) == 0), W'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) != 0), "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
